// File: rtl/cla_seq_pkg.sv
// Shared definitions for the byte-serial CLA add/subtract sequencer:
// state encoding, datapath byte width and the byte-counter width helper.
package cla_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Width of a counter that must index bytes 0..nbytes-1 (at least 1 bit).
    function automatic int cnt_w(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/cla8.sv
// Combinational 8-bit carry-lookahead adder with carry-in.
// Every carry is built directly from generate/propagate terms and the
// carry-in (no rippling through lower carries). c7 is the carry into the
// top bit, which the sequencer needs for signed overflow detection.
module cla8
    import cla_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout,
    output logic              c7
);

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < BYTE_W; gi++) begin : g_carry
            logic cbit;

            // Lookahead carry into bit gi+1: OR of every generate term
            // propagated up to here, plus the carry-in propagated all the way.
            always_comb begin
                logic term;
                logic acc;
                term = cin;
                for (int j = 0; j <= gi; j++) term = term & p[j];
                acc = term;
                for (int k = 0; k <= gi; k++) begin
                    term = g[k];
                    for (int j = k + 1; j <= gi; j++) term = term & p[j];
                    acc = acc | term;
                end
                cbit = acc;
            end

            assign c[gi+1] = cbit;
        end
    endgenerate

    assign sum  = p ^ c[BYTE_W-1:0];
    assign cout = c[BYTE_W];
    assign c7   = c[BYTE_W-1];

endmodule

// File: rtl/cla_byte_sequencer.sv
// Byte-serial multi-precision adder/subtractor around one shared cla8.
// Operand pairs arrive LS byte first; each result byte leaves through a
// registered valid/ready output stage. Carry/overflow/zero flags are
// reported when the final byte has been handed off.
// Optional feature macro: CLA_SEQ_SUB_EN enables subtraction via op_sub;
// without it the block is add-only and op_sub is kept only as a pin.
module cla_byte_sequencer
    import cla_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_sub,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] a_in,
    input  logic [BYTE_W-1:0] b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] sum_out,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              flag_c,
    output logic              flag_v,
    output logic              flag_z
);

    localparam int CW = cnt_w(NBYTES);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

    state_t            state_reg;
    logic              sub_reg;
    logic              carry_reg;
    logic              zero_reg;
    logic [CW-1:0]     count_reg;

    logic              start_sub;
    logic              accept;
    logic              last_now;
    logic [BYTE_W-1:0] b_eff;
    logic [BYTE_W-1:0] s;
    logic              cout;
    logic              c7;

`ifdef CLA_SEQ_SUB_EN
    assign start_sub = op_sub;
`else
    // Add-only build: the pin exists but never influences the datapath.
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign start_sub     = 1'b0;
`endif

    // Take a new pair only when the output slot is empty or draining now.
    assign in_ready = (state_reg == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_now = (count_reg == LAST_CNT);
    assign busy     = (state_reg != IDLE);
    assign b_eff    = b_in ^ {BYTE_W{sub_reg}};

    cla8 u_cla8 (
        .a    (a_in),
        .b    (b_eff),
        .cin  (carry_reg),
        .sum  (s),
        .cout (cout),
        .c7   (c7)
    );

    // Sequencer FSM with registered output stage and flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
            count_reg <= '0;
            out_valid <= 1'b0;
            sum_out   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_z    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sub_reg   <= start_sub;
                        carry_reg <= start_sub;
                        count_reg <= '0;
                        zero_reg  <= 1'b1;
                        flag_c    <= 1'b0;
                        flag_v    <= 1'b0;
                        flag_z    <= 1'b0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        sum_out   <= s;
                        out_valid <= 1'b1;
                        out_last  <= last_now;
                        carry_reg <= cout;
                        zero_reg  <= zero_reg & (s == '0);
                        count_reg <= count_reg + 1'b1;
                        if (last_now) begin
                            flag_c    <= cout;
                            flag_v    <= cout ^ c7;
                            state_reg <= FLUSH;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        flag_z    <= zero_reg;
                        done      <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_byte_sequencer.sv
// Directed bench for cla_byte_sequencer (NBYTES=4): table of operations with
// hand-computed results/flags, plus reset-mid-operation and start-while-busy
// sequences. Expected values follow the CLA_SEQ_SUB_EN build setting.
module tb_cla_byte_sequencer;

    localparam int NB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op_sub;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum_out;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       flag_c;
    logic       flag_v;
    logic       flag_z;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cla_byte_sequencer #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_sub    (op_sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z)
    );

    typedef struct {
        string       name;
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        bit          stall;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All outputs at their reset values, packed into one word.
    function automatic logic [15:0] out_vec();
        return {2'b00, in_ready, out_valid, sum_out, out_last, busy, done, flag_c, flag_v, flag_z};
    endfunction

    // Runs one operation; starts at a negedge, returns one cycle after done.
    task automatic run_op(input string tag, input logic sub, input logic [31:0] a,
                          input logic [31:0] b, input bit stall, input bit spam,
                          output logic [31:0] res, output int nout, output int done_cyc);
        int  nin;
        bit  got_done;
        bit  pstall;
        logic [7:0] psum;
        logic       plast;
        nin = 0; nout = 0; done_cyc = -1; got_done = 0; pstall = 0;
        psum = 8'h00; plast = 1'b0; res = 32'h0;
        @(negedge clk);
        start = 1'b1; op_sub = sub; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 check({tag, "_flags_clear"}, {flag_c, flag_v, flag_z}, 3'b000);
        for (int cyc = 1; cyc < 300 && !got_done; cyc++) begin
            if (cyc > 1) @(negedge clk);
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = spam && busy;
            op_sub    = ~sub;
            in_valid  = (nin < NB);
            a_in      = (nin < NB) ? a[8*nin +: 8] : 8'h00;
            b_in      = (nin < NB) ? b[8*nin +: 8] : 8'h00;
            #1;
            if (out_valid && !out_ready)
                check({tag, "_stall_in_ready"}, in_ready, 1'b0);
            if (pstall)
                check({tag, "_stall_hold"}, {out_valid, out_last, sum_out}, {1'b1, plast, psum});
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (nout < NB) res[8*nout +: 8] = sum_out;
                check({tag, "_out_last"}, out_last, (nout == NB - 1));
                nout++;
            end
            if (in_valid && in_ready) nin++;
            pstall = out_valid && !out_ready;
            psum   = sum_out;
            plast  = out_last;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check({tag, "_done_seen"}, got_done, 1'b1);
        @(negedge clk);
        #1 check({tag, "_done_pulse"}, {done, busy}, 2'b00);
    endtask

    initial begin
        logic [31:0] res;
        int nout;
        int dcyc;

        vecs[0] = '{"add_ff_1",   1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"add_wrap",   1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"add_ovf",    1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{"add_bp",     1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef CLA_SEQ_SUB_EN
        vecs[3] = '{"sub_5_7",    1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"sub_bp",     1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{"sub_7_7",    1'b1, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        vecs[3] = '{"sub_5_7",    1'b1, 32'h00000005, 32'h00000007, 32'h0000000C, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"sub_bp",     1'b1, 32'h80000000, 32'h00000001, 32'h80000001, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{"sub_7_7",    1'b1, 32'h00000007, 32'h00000007, 32'h0000000E, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; in_valid = 1'b0;
        a_in = 8'h00; b_in = 8'h00; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset_values", 64'(out_vec()), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].stall, 1'b0, res, nout, dcyc);
            check({vecs[i].name, "_result"}, res, vecs[i].res);
            check({vecs[i].name, "_flags"}, {flag_c, flag_v, flag_z}, {vecs[i].c, vecs[i].v, vecs[i].z});
            check({vecs[i].name, "_byte_count"}, nout, NB);
            if (!vecs[i].stall)
                check({vecs[i].name, "_latency"}, dcyc, NB + 2);
            $display("[TB] op %s: result=%08h c=%0b v=%0b z=%0b bytes=%0d done_cycle=%0d",
                     vecs[i].name, res, flag_c, flag_v, flag_z, nout, dcyc);
        end

        // Reset in the middle of an operation, after two bytes were accepted.
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; a_in = 8'h11; b_in = 8'h22;
        @(negedge clk);
        a_in = 8'h33; b_in = 8'h44;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1 check("mid_op_active", {out_valid, busy, sum_out}, {1'b1, 1'b1, 8'h77});
        #1 rst_n = 1'b0;
        #1 check("async_reset_values", 64'(out_vec()), 64'h0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 check("post_reset_idle", 64'(out_vec()), 64'h0);
        $display("[TB] op mid_reset: outputs=%04h after reset", out_vec());

        // Fresh operation with start pulses (and flipped op_sub) while busy.
        run_op("post_reset", 1'b0, 32'h01020304, 32'h10203040, 1'b0, 1'b1, res, nout, dcyc);
        check("post_reset_result", res, 32'h11223344);
        check("post_reset_flags", {flag_c, flag_v, flag_z}, 3'b000);
        check("post_reset_byte_count", nout, NB);
        check("post_reset_latency", dcyc, NB + 2);
        $display("[TB] op post_reset: result=%08h c=%0b v=%0b z=%0b bytes=%0d done_cycle=%0d",
                 res, flag_c, flag_v, flag_z, nout, dcyc);
        repeat (2) @(negedge clk);
        #1 check("idle_after_spam", {busy, done, out_valid}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
